// File: rtl/priority_resolver.sv
// ============================================================================
// Module   : priority_resolver
// Purpose  : 8259-style priority resolver, in-service register and INTA FSM.
//            Optional macro PRIORITY_ROTATION_EN enables EOI/AEOI rotation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_resolver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] risedBits,
  input  logic       inta_n,
  input  logic [4:0] vectorBase,
  input  logic       autoEoi,
  input  logic       eoiCmd,
  input  logic       eoiSpecific,
  input  logic [2:0] eoiLevel,
  input  logic       eoiRotate,
  input  logic       readPriorityAck,
  output logic       intOut,
  output logic       readPriority,
  output logic [2:0] resetIRR,
  output logic [7:0] vectorOut,
  output logic       vectorOE,
  output logic [7:0] isr,
  output logic [2:0] lowestPri
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_ACK1  = 3'd2,
    S_WAIT2 = 3'd3,
    S_ACK2  = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_inta_prev;
  logic [2:0] r_level;
  logic       r_spur;
  logic       r_ack_sample;
  logic [7:0] r_isr;
  logic [2:0] w_lowest;

  logic       w_fall;
  logic       w_enter_ack1;
  logic       w_enter_ack2;
  logic       w_spur_entry;
  logic       w_valid;
  logic [3:0] w_req_top;
  logic [3:0] w_isr_top;
  logic [2:0] w_req_rank;
  logic [2:0] w_isr_rank;
  logic [7:0] w_eoi_mask;
  logic [7:0] w_set_mask;
  logic [7:0] w_aeoi_mask;

  // Returns {found, level} of the highest-priority set bit; scanning from the
  // lowest-priority level upward lets the last hit win.
  function automatic logic [3:0] find_top(input logic [7:0] bits, input logic [2:0] low);
    logic [3:0] res;
    logic [2:0] lvl;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      lvl = low + 3'd1 + i[2:0];
      if (bits[lvl]) res = {1'b1, lvl};
    end
    return res;
  endfunction

  assign w_fall     = r_inta_prev & ~inta_n;
  assign w_req_top  = find_top(risedBits, w_lowest);
  assign w_isr_top  = find_top(r_isr, w_lowest);
  assign w_req_rank = w_req_top[2:0] - w_lowest - 3'd1;
  assign w_isr_rank = w_isr_top[2:0] - w_lowest - 3'd1;
  assign w_valid    = w_req_top[3] & (~w_isr_top[3] | (w_req_rank < w_isr_rank));

  always_comb begin
    w_next       = r_state;
    w_enter_ack1 = 1'b0;
    w_enter_ack2 = 1'b0;
    w_spur_entry = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_next       = S_WAIT2;
          w_spur_entry = 1'b1;
        end else if (w_valid) begin
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        if (w_fall && w_valid) begin
          w_next       = S_ACK1;
          w_enter_ack1 = 1'b1;
        end else if (w_fall) begin
          w_next       = S_WAIT2;
          w_spur_entry = 1'b1;
        end else if (!w_valid) begin
          w_next = S_IDLE;
        end
      end
      S_ACK1: begin
        if (readPriorityAck != r_ack_sample) w_next = S_WAIT2;
      end
      S_WAIT2: begin
        if (w_fall) begin
          w_next       = S_ACK2;
          w_enter_ack2 = 1'b1;
        end
      end
      S_ACK2: begin
        if (inta_n) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_eoi_mask = 8'h00;
    if (eoiCmd) begin
      if (eoiSpecific)       w_eoi_mask = 8'b1 << eoiLevel;
      else if (w_isr_top[3]) w_eoi_mask = 8'b1 << w_isr_top[2:0];
    end
  end

  assign w_set_mask  = w_enter_ack1 ? (8'b1 << w_req_top[2:0]) : 8'h00;
  assign w_aeoi_mask = (w_enter_ack2 && autoEoi && !r_spur) ? (8'b1 << r_level) : 8'h00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_inta_prev  <= 1'b1;
      r_level      <= 3'd0;
      r_spur       <= 1'b0;
      r_ack_sample <= 1'b0;
      r_isr        <= 8'h00;
    end else begin
      r_state     <= w_next;
      r_inta_prev <= inta_n;
      // EOI is applied before the new in-service bit is set.
      r_isr       <= ((r_isr & ~w_eoi_mask) | w_set_mask) & ~w_aeoi_mask;
      if (w_enter_ack1) begin
        r_level      <= w_req_top[2:0];
        r_spur       <= 1'b0;
        r_ack_sample <= readPriorityAck;
      end else if (w_spur_entry) begin
        r_level <= 3'd7;
        r_spur  <= 1'b1;
      end
    end
  end

`ifdef PRIORITY_ROTATION_EN
  logic [2:0] r_lowest;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lowest <= 3'd7;
    end else if (eoiCmd && eoiRotate && eoiSpecific) begin
      r_lowest <= eoiLevel;
    end else if (eoiCmd && eoiRotate && w_isr_top[3]) begin
      r_lowest <= w_isr_top[2:0];
    end else if (w_aeoi_mask != 8'h00 && eoiRotate) begin
      r_lowest <= r_level;
    end
  end

  assign w_lowest = r_lowest;
`else
  logic w_unused;
  assign w_unused = eoiRotate;
  assign w_lowest = 3'd7;
`endif

  assign intOut       = (r_state == S_REQ) || (r_state == S_ACK1) || (r_state == S_WAIT2);
  assign readPriority = (r_state == S_ACK1);
  assign resetIRR     = (r_state == S_ACK1) ? r_level : 3'd0;
  assign vectorOE     = (r_state == S_ACK2) && !inta_n;
  assign vectorOut    = vectorOE ? {vectorBase, r_level} : 8'h00;
  assign isr          = r_isr;
  assign lowestPri    = w_lowest;

endmodule

`default_nettype wire

// File: tb/tb_priority_resolver.sv
// ============================================================================
// Module   : tb_priority_resolver
// Purpose  : Directed scoreboard bench for priority_resolver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_priority_resolver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] risedBits;
  logic       inta_n;
  logic [4:0] vectorBase;
  logic       autoEoi;
  logic       eoiCmd;
  logic       eoiSpecific;
  logic [2:0] eoiLevel;
  logic       eoiRotate;
  logic       readPriorityAck;
  logic       intOut;
  logic       readPriority;
  logic [2:0] resetIRR;
  logic [7:0] vectorOut;
  logic       vectorOE;
  logic [7:0] isr;
  logic [2:0] lowestPri;

`ifdef PRIORITY_ROTATION_EN
  localparam logic [2:0] ROT_LOW = 3'd3;
  localparam logic [2:0] ROT_L   = 3'd4;
`else
  localparam logic [2:0] ROT_LOW = 3'd7;
  localparam logic [2:0] ROT_L   = 3'd3;
`endif

  localparam int S_INT = 0, S_ISR = 1, S_LOW = 2, S_RDP = 3, S_IRR = 4, S_OE = 5, S_VEC = 6;

  typedef struct {
    string      tag;
    int         sig;
    logic [7:0] val;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  priority_resolver dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .risedBits       (risedBits),
    .inta_n          (inta_n),
    .vectorBase      (vectorBase),
    .autoEoi         (autoEoi),
    .eoiCmd          (eoiCmd),
    .eoiSpecific     (eoiSpecific),
    .eoiLevel        (eoiLevel),
    .eoiRotate       (eoiRotate),
    .readPriorityAck (readPriorityAck),
    .intOut          (intOut),
    .readPriority    (readPriority),
    .resetIRR        (resetIRR),
    .vectorOut       (vectorOut),
    .vectorOE        (vectorOE),
    .isr             (isr),
    .lowestPri       (lowestPri)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs(input int s);
    case (s)
      S_INT:   return {7'd0, intOut};
      S_ISR:   return isr;
      S_LOW:   return {5'd0, lowestPri};
      S_RDP:   return {7'd0, readPriority};
      S_IRR:   return {5'd0, resetIRR};
      S_OE:    return {7'd0, vectorOE};
      default: return vectorOut;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sig, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    q.push_back(e);
  endtask

  // Advance one clock, then pop and compare every queued expectation.
  task automatic tick();
    exp_t       e;
    logic [7:0] o;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = obs(e.sig);
      n_tests++;
      assert (o === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic reset_exps(input string tag);
    expect_val({tag, "_int"}, S_INT, 8'h00);
    expect_val({tag, "_isr"}, S_ISR, 8'h00);
    expect_val({tag, "_low"}, S_LOW, 8'h07);
    expect_val({tag, "_rdp"}, S_RDP, 8'h00);
    expect_val({tag, "_irr"}, S_IRR, 8'h00);
    expect_val({tag, "_oe"},  S_OE,  8'h00);
    expect_val({tag, "_vec"}, S_VEC, 8'h00);
  endtask

  // Two-pulse acknowledge starting from the REQ state.
  task automatic full_ack(input string tag, input logic [2:0] lvl,
                          input logic [7:0] isr1, input logic [7:0] isr2);
    inta_n = 1'b0;
    expect_val({tag, "_irr"}, S_IRR, {5'd0, lvl});
    expect_val({tag, "_isr1"}, S_ISR, isr1);
    tick();
    readPriorityAck = ~readPriorityAck;
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    expect_val({tag, "_vec"}, S_VEC, {vectorBase, lvl});
    expect_val({tag, "_isr2"}, S_ISR, isr2);
    tick();
    inta_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; inta_n = 1'b1; risedBits = 8'h00; vectorBase = 5'h08;
    autoEoi = 1'b0; eoiCmd = 1'b0; eoiSpecific = 1'b0; eoiLevel = 3'd0;
    eoiRotate = 1'b0; readPriorityAck = 1'b0;
    reset_exps("rst");
    tick();
    rst_n = 1'b1;
    tick();

    // Basic two-pulse acknowledge of IR2
    risedBits = 8'h24;
    expect_val("basic_int_req", S_INT, 8'h01);
    tick();
    inta_n = 1'b0;
    expect_val("basic_isr", S_ISR, 8'h04);
    expect_val("basic_irr", S_IRR, 8'h02);
    expect_val("basic_rdp", S_RDP, 8'h01);
    tick();
    inta_n = 1'b1;
    expect_val("basic_rdp_hold", S_RDP, 8'h01);
    tick();
    readPriorityAck = 1'b1;
    expect_val("basic_rdp_drop", S_RDP, 8'h00);
    expect_val("basic_int_wait2", S_INT, 8'h01);
    tick();
    inta_n = 1'b0;
    expect_val("basic_oe", S_OE, 8'h01);
    expect_val("basic_vec", S_VEC, 8'h42);
    expect_val("basic_int_ack2", S_INT, 8'h00);
    tick();
    inta_n = 1'b1;
    risedBits = 8'h00;
    expect_val("basic_oe_off", S_OE, 8'h00);
    expect_val("basic_vec_off", S_VEC, 8'h00);
    expect_val("basic_isr_keep", S_ISR, 8'h04);
    tick();

    // Fully nested masking, then non-specific EOI unblocks
    eoiCmd = 1'b1;
    expect_val("eoi_ns_clear", S_ISR, 8'h00);
    tick();
    eoiCmd = 1'b0;
    risedBits = 8'h02;
    tick();
    full_ack("nest_ack", 3'd1, 8'h02, 8'h02);
    risedBits = 8'h08;
    expect_val("nest_block", S_INT, 8'h00);
    tick();
    eoiCmd = 1'b1;
    expect_val("nest_eoi_isr", S_ISR, 8'h00);
    expect_val("nest_eoi_int", S_INT, 8'h00);
    tick();
    eoiCmd = 1'b0;
    expect_val("nest_unblock", S_INT, 8'h01);
    tick();
    risedBits = 8'h00;
    expect_val("nest_drop", S_INT, 8'h00);
    tick();

    // Request withdrawn before INTA
    risedBits = 8'h01;
    expect_val("cease_int_up", S_INT, 8'h01);
    tick();
    risedBits = 8'h00;
    expect_val("cease_int_dn", S_INT, 8'h00);
    expect_val("cease_isr", S_ISR, 8'h00);
    tick();

    // Spurious acknowledge
    inta_n = 1'b0;
    expect_val("spur_rdp", S_RDP, 8'h00);
    expect_val("spur_isr", S_ISR, 8'h00);
    tick();
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    expect_val("spur_vec", S_VEC, 8'h47);
    expect_val("spur_oe", S_OE, 8'h01);
    expect_val("spur_isr2", S_ISR, 8'h00);
    tick();
    inta_n = 1'b1;
    tick();

    // EOI in the same clock as an in-service set
    risedBits = 8'h04;
    tick();
    full_ack("pre_same", 3'd2, 8'h04, 8'h04);
    risedBits = 8'h01;
    tick();
    inta_n = 1'b0;
    eoiCmd = 1'b1;
    expect_val("same_clk_isr", S_ISR, 8'h01);
    expect_val("same_clk_irr", S_IRR, 8'h00);
    tick();
    eoiCmd = 1'b0;
    readPriorityAck = ~readPriorityAck;
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    expect_val("same_clk_vec", S_VEC, 8'h40);
    tick();
    inta_n = 1'b1;
    risedBits = 8'h00;
    tick();
    eoiCmd = 1'b1; eoiSpecific = 1'b1; eoiLevel = 3'd5;
    expect_val("spec_noop", S_ISR, 8'h01);
    tick();
    eoiLevel = 3'd0;
    expect_val("spec_clear", S_ISR, 8'h00);
    tick();
    eoiCmd = 1'b0; eoiSpecific = 1'b0;

    // Automatic EOI
    autoEoi = 1'b1;
    risedBits = 8'h08;
    tick();
    full_ack("aeoi", 3'd3, 8'h08, 8'h00);
    autoEoi = 1'b0;

    // Rotation on specific EOI (constant lowest level when disabled)
    tick();
    full_ack("rot_pre", 3'd3, 8'h08, 8'h08);
    risedBits = 8'h00;
    eoiCmd = 1'b1; eoiSpecific = 1'b1; eoiLevel = 3'd3; eoiRotate = 1'b1;
    expect_val("rot_isr", S_ISR, 8'h00);
    expect_val("rot_low", S_LOW, {5'd0, ROT_LOW});
    tick();
    eoiCmd = 1'b0; eoiSpecific = 1'b0; eoiRotate = 1'b0;
    risedBits = 8'h18;
    tick();
    full_ack("rot_win", ROT_L, 8'h01 << ROT_L, 8'h01 << ROT_L);
    risedBits = 8'h00;
    eoiCmd = 1'b1; eoiSpecific = 1'b1; eoiLevel = ROT_L;
    expect_val("rot_clear", S_ISR, 8'h00);
    tick();
    eoiCmd = 1'b0; eoiSpecific = 1'b0;

    // Reset in the middle of an acknowledge
    risedBits = 8'h40;
    tick();
    inta_n = 1'b0;
    tick();
    readPriorityAck = ~readPriorityAck;
    inta_n = 1'b1;
    expect_val("mid_wait2_int", S_INT, 8'h01);
    expect_val("mid_wait2_isr", S_ISR, 8'h40);
    tick();
    rst_n = 1'b0;
    reset_exps("midrst");
    tick();
    rst_n = 1'b1;
    risedBits = 8'h00;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
